noc_wr_stream: RTL and testbench
================================

# noc_wr_stream

Parametrised NoC write-stream receiver for the permutation datapath. It parses byte-serial NoC command packets and concatenates the write payload bytes of successive packets into WORD_W-bit words. It buffers those words in a FIFO and streams them to the perm block with back-pressure, flagging the first word of every BLOCK_WORDS-word block. It returns write responses and error messages on the NoC return channel; read and message commands are not serviced here.

## Interface
- WORD_W, 64, downstream word width; a multiple of 8, ≥ 8. WB = WORD_W/8 bytes per word.
- BLOCK_WORDS, 25, words per perm block; ≥ 1.
- FIFO_DEPTH, 4, word FIFO depth; a power of 2, ≥ 2.
- DEV_ID, 8'h01, source ID placed in error messages.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- noc_to_dev_ctl  in  1  1 = header byte.
- noc_to_dev_data  in  8  inbound NoC byte, one per cycle.
- noc_from_dev_ctl  out  1  1 = response header byte.
- noc_from_dev_data  out  8  outbound NoC byte.
- pushin  out  1  din is valid.
- firstin  out  1  din is word 0 of a block.
- din  out  WORD_W  word to perm; byte i is at bits [8i+7:8i].
- stopin  in  1  1 = perm cannot accept.

## Operation
- Header fields:
  - [7:6] alen code: 0..3 → 1, 2, 4 or 8 address bytes.
  - [5:3] dlen code: n → 2^n bytes.
  - [2:0] cmd: 010 = write, 001 = read; any other value is ignored.
- Receive FSM states: IDLE, DEST, SRC, ADDR, DATA, SKIP.
- IDLE:
  - ctl=0 bytes are ignored.
  - A header with cmd=010 latches alen and dlen, clears the packet rc, and goes to DEST.
  - A header with cmd=001 queues error message code 8'h04 and goes to SKIP.
  - Any other header goes to SKIP.
- DEST, SRC: latch the ID byte.
  - A zero ID queues error message code 8'h03 and goes to SKIP.
  - A nonzero ID advances to the next state.
- ADDR: consumes alen bytes. Address bytes are discarded; this block streams data without addressing.
- DATA:
  - Consumes 2^dlen bytes into the word assembler; the byte counter is 8 bits and holds up to 128.
  - After the last byte, queue a write response and return to IDLE.
- SKIP: ignores ctl=0 bytes.
- A ctl=1 byte in any state is a new header and is handled as in IDLE. Any in-progress packet is aborted with no response, and the partial word is cleared.
- Word assembler:
  - Fills bytes 0..WB-1 in order.
  - The partial word carries across packet boundaries.
  - A full word is pushed to the FIFO. If the FIFO is full, the word is dropped and the current packet's rc is set to 2'b10.
- Write response: {rc, 6'b000100}, received src, received dest, byte count. The byte count is 2^dlen truncated to 8 bits.
- Error message: 8'h05, 8'h00, DEV_ID, 8'h42, code.
- Response sender:
  - Sends one response at a time, with one pending slot.
  - If a response is queued while the sender is busy and the slot is full, the new response is dropped.
- Output side:
  - pushin = FIFO not empty; din is the FIFO head.
  - A transfer occurs on an edge where pushin=1 and stopin=0.
  - A block word counter (0..BLOCK_WORDS-1, wrapping) advances on each transfer.
  - firstin = pushin && (counter == 0).
- Simultaneous FIFO push and pop when full: the pop frees the slot, so the push succeeds and no word is dropped.

## Timing
- Reset (asynchronous, rst_n=0):
  - All outputs are 0: noc_from_dev_ctl, noc_from_dev_data, pushin, firstin, din.
  - FSMs go to IDLE; FIFO, assembler, block counter and pending slot are cleared.
  - Reset mid-packet or mid-response abandons it entirely.
- Inbound bytes are sampled every edge; there is no inbound stall.
- Word latency: the last byte of a word is sampled at edge k. The word is in the FIFO after edge k. If the FIFO was empty, pushin=1 in cycle k+1.
- While stopin=1, pushin, firstin and din are held stable.
- Response latency:
  - Last data byte sampled at edge k → response header appears on the outputs after edge k+1, if the sender is idle.
  - Subsequent response bytes follow on consecutive cycles.
  - noc_from_dev_ctl=1 only on the header byte; data is 0 when idle.
- A pending response starts the cycle after the previous one's last byte.

## Test plan
- Basic write, WORD_W=64:
  - Stimulus: 1A; 05 09 00; data 01..08.
  - Required: din=64'h0807060504030201 with pushin=1, firstin=1.
  - Required response: ctl=1 04, then 09 05 08.
- Block framing, BLOCK_WORDS=25:
  - Stimulus: writes of 128 + 64 + 8 + 8 bytes.
  - Required: 26 words; firstin only on words 0 and 25.
- Overflow, FIFO_DEPTH=4:
  - Stimulus: stopin held 1, then a 64-byte write.
  - Required: 4 words kept, 4 dropped; response header 84, length 40.
  - Then release stopin: words 0..3 are emitted unchanged.
- Zero ID: header 1A, dest 00.
  - Required: message 05 00 01 42 03.
  - Following ctl=0 bytes are ignored; the FIFO is unchanged.
- Read command: header 01.
  - Required: message 05 00 01 42 04.
- Abort and reset:
  - A new header after 3 data bytes clears the partial word and sends no response.
  - rst_n pulsed low mid-stream clears all outputs to 0 immediately.

Source files
------------

// File: rtl/noc_wr_stream_if.sv
// ---------------------------------------------------------------------------
// noc_wr_stream_if
// Bundles the NoC byte channels and the perm word stream of noc_wr_stream.
//   noc_to_dev_ctl / noc_to_dev_data     : inbound NoC byte, ctl=1 on header
//   noc_from_dev_ctl / noc_from_dev_data : outbound NoC byte, ctl=1 on header
//   pushin / firstin / din               : word stream towards perm
//   stopin                               : perm back-pressure
// Modports: master = NoC/perm side (testbench), slave = the receiver block.
// ---------------------------------------------------------------------------
interface noc_wr_stream_if #(
    parameter int WORD_W = 64
);
    logic              noc_to_dev_ctl;
    logic [7:0]        noc_to_dev_data;
    logic              noc_from_dev_ctl;
    logic [7:0]        noc_from_dev_data;
    logic              pushin;
    logic              firstin;
    logic [WORD_W-1:0] din;
    logic              stopin;

    modport master (
        output noc_to_dev_ctl, noc_to_dev_data, stopin,
        input  noc_from_dev_ctl, noc_from_dev_data, pushin, firstin, din
    );

    modport slave (
        input  noc_to_dev_ctl, noc_to_dev_data, stopin,
        output noc_from_dev_ctl, noc_from_dev_data, pushin, firstin, din
    );
endinterface

// File: rtl/noc_wr_stream.sv
// ---------------------------------------------------------------------------
// noc_wr_stream
// Parses byte-serial NoC command packets, packs the write payload of
// successive packets into WORD_W-bit words, buffers them in a small FIFO and
// streams them to the perm block with back-pressure. The first word of every
// BLOCK_WORDS-word block is flagged with firstin. Write responses and error
// messages are returned on the NoC return channel.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : noc_wr_stream_if.slave (NoC in/out bytes, pushin/firstin/din,
//           stopin)
// ---------------------------------------------------------------------------
module noc_wr_stream #(
    parameter int         WORD_W      = 64,
    parameter int         BLOCK_WORDS = 25,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] DEV_ID      = 8'h01
) (
    input  logic           clk,
    input  logic           rst_n,
    noc_wr_stream_if.slave bus
);
    localparam int WB = WORD_W / 8;
    localparam int IW = (WB > 1) ? $clog2(WB) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DEST, S_SRC, S_ADDR, S_DATA, S_SKIP
    } state_t;

    // -----------------------------------------------------------------------
    // Inbound byte
    // -----------------------------------------------------------------------
    logic       w_in_ctl;
    logic [7:0] w_in_data;
    assign w_in_ctl  = bus.noc_to_dev_ctl;
    assign w_in_data = bus.noc_to_dev_data;

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;          // bytes remaining in ADDR/DATA, minus one
    logic [7:0] w_cnt_next;
    logic [1:0] r_alen;
    logic [2:0] r_dlen;
    logic [7:0] r_dest;
    logic [7:0] r_src;
    logic [1:0] r_rc;

    logic       w_hdr_wr;
    logic       w_abort;
    logic       w_latch_dest;
    logic       w_latch_src;
    logic       w_data_byte;
    logic       w_wr_done;
    logic       w_err_req;
    logic [7:0] w_err_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hdr_wr     = 1'b0;
        w_abort      = 1'b0;
        w_latch_dest = 1'b0;
        w_latch_src  = 1'b0;
        w_data_byte  = 1'b0;
        w_wr_done    = 1'b0;
        w_err_req    = 1'b0;
        w_err_code   = 8'h00;
        if (w_in_ctl) begin
            // A header always restarts parsing; a packet still being parsed
            // is abandoned together with its partially assembled word.
            w_abort = (r_state == S_DEST) || (r_state == S_SRC) ||
                      (r_state == S_ADDR) || (r_state == S_DATA);
            if (w_in_data[2:0] == 3'b010) begin
                w_hdr_wr     = 1'b1;
                w_state_next = S_DEST;
            end else begin
                w_state_next = S_SKIP;
                if (w_in_data[2:0] == 3'b001) begin
                    w_err_req  = 1'b1;
                    w_err_code = 8'h04;
                end
            end
        end else begin
            unique case (r_state)
                S_DEST: begin
                    if (w_in_data == 8'h00) begin
                        w_err_req    = 1'b1;
                        w_err_code   = 8'h03;
                        w_state_next = S_SKIP;
                    end else begin
                        w_latch_dest = 1'b1;
                        w_state_next = S_SRC;
                    end
                end
                S_SRC: begin
                    if (w_in_data == 8'h00) begin
                        w_err_req    = 1'b1;
                        w_err_code   = 8'h03;
                        w_state_next = S_SKIP;
                    end else begin
                        w_latch_src  = 1'b1;
                        w_state_next = S_ADDR;
                        w_cnt_next   = (8'd1 << r_alen) - 8'd1;
                    end
                end
                S_ADDR: begin
                    // Address bytes are consumed and discarded.
                    if (r_cnt == 8'd0) begin
                        w_state_next = S_DATA;
                        w_cnt_next   = (8'd1 << r_dlen) - 8'd1;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
                S_DATA: begin
                    w_data_byte = 1'b1;
                    if (r_cnt == 8'd0) begin
                        w_wr_done    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
                default: begin
                    // IDLE and SKIP ignore payload bytes.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO status (needed by the assembler to decide push vs. drop)
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_word_done;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && !bus.stopin;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign w_push  = w_word_done && (!w_full || w_pop);
    assign w_drop  = w_word_done && !w_push;

    // Packet registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 8'd0;
            r_alen <= 2'd0;
            r_dlen <= 3'd0;
            r_dest <= 8'd0;
            r_src  <= 8'd0;
            r_rc   <= 2'b00;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_hdr_wr) begin
                r_alen <= w_in_data[7:6];
                r_dlen <= w_in_data[5:3];
                r_rc   <= 2'b00;
            end else if (w_drop) begin
                r_rc <= 2'b10;
            end
            if (w_latch_dest) begin
                r_dest <= w_in_data;
            end
            if (w_latch_src) begin
                r_src <= w_in_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Word assembler: byte lane gi takes the incoming byte when selected
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0] r_asm;
    logic [IW-1:0]     r_byte_idx;
    logic [WORD_W-1:0] w_word;

    generate
        for (genvar gi = 0; gi < WB; gi++) begin : g_lane
            assign w_word[8*gi +: 8] = (r_byte_idx == IW'(gi)) ? w_in_data
                                                                : r_asm[8*gi +: 8];
        end
    endgenerate

    assign w_word_done = w_data_byte && (r_byte_idx == IW'(WB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm      <= '0;
            r_byte_idx <= '0;
        end else if (w_abort) begin
            r_asm      <= '0;
            r_byte_idx <= '0;
        end else if (w_data_byte) begin
            if (w_word_done) begin
                r_asm      <= '0;
                r_byte_idx <= '0;
            end else begin
                r_asm      <= w_word;
                r_byte_idx <= r_byte_idx + IW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Word FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_word;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Block framing
    // -----------------------------------------------------------------------
    logic [BW-1:0] r_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= '0;
        end else if (w_pop) begin
            if (r_blk == BW'(BLOCK_WORDS - 1)) begin
                r_blk <= '0;
            end else begin
                r_blk <= r_blk + BW'(1);
            end
        end
    end

    assign bus.pushin  = !w_empty;
    assign bus.firstin = !w_empty && (r_blk == '0);
    assign bus.din     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // -----------------------------------------------------------------------
    // Response sender with a single pending slot
    // Responses are held as up to 5 bytes, byte 0 in the low bits.
    // -----------------------------------------------------------------------
    logic        w_rsp_req;
    logic [39:0] w_rsp_bytes;
    logic [2:0]  w_rsp_len;
    logic [1:0]  w_rc_final;
    logic [7:0]  w_len8;

    logic        r_pend_valid;
    logic [39:0] r_pend_bytes;
    logic [2:0]  r_pend_len;
    logic [39:0] r_tx_bytes;
    logic [2:0]  r_tx_remain;     // bytes still to send after the current one
    logic        r_out_ctl;
    logic [7:0]  r_out_data;
    logic        w_tx_load;

    // A word dropped on the final data byte must still show in this rc.
    assign w_rc_final = r_rc | (w_drop ? 2'b10 : 2'b00);
    assign w_len8     = 8'd1 << r_dlen;
    assign w_rsp_req  = w_wr_done || w_err_req;

    always_comb begin
        w_rsp_bytes = '0;
        w_rsp_len   = 3'd0;
        if (w_wr_done) begin
            w_rsp_bytes = {8'h00, w_len8, r_dest, r_src, {w_rc_final, 6'b000100}};
            w_rsp_len   = 3'd4;
        end else if (w_err_req) begin
            w_rsp_bytes = {w_err_code, 8'h42, DEV_ID, 8'h00, 8'h05};
            w_rsp_len   = 3'd5;
        end
    end

    assign w_tx_load = (r_tx_remain == 3'd0) && r_pend_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_bytes <= '0;
            r_pend_len   <= 3'd0;
            r_tx_bytes   <= '0;
            r_tx_remain  <= 3'd0;
            r_out_ctl    <= 1'b0;
            r_out_data   <= 8'h00;
        end else begin
            // The slot takes a new response when empty or being handed to
            // the sender on this edge; otherwise the new one is dropped.
            if (w_rsp_req && (!r_pend_valid || w_tx_load)) begin
                r_pend_valid <= 1'b1;
                r_pend_bytes <= w_rsp_bytes;
                r_pend_len   <= w_rsp_len;
            end else if (w_tx_load) begin
                r_pend_valid <= 1'b0;
            end

            if (r_tx_remain != 3'd0) begin
                r_out_ctl   <= 1'b0;
                r_out_data  <= r_tx_bytes[7:0];
                r_tx_bytes  <= r_tx_bytes >> 8;
                r_tx_remain <= r_tx_remain - 3'd1;
            end else if (r_pend_valid) begin
                r_out_ctl   <= 1'b1;
                r_out_data  <= r_pend_bytes[7:0];
                r_tx_bytes  <= r_pend_bytes >> 8;
                r_tx_remain <= r_pend_len - 3'd1;
            end else begin
                r_out_ctl  <= 1'b0;
                r_out_data <= 8'h00;
            end
        end
    end

    assign bus.noc_from_dev_ctl  = r_out_ctl;
    assign bus.noc_from_dev_data = r_out_data;

endmodule

// File: tb/tb_noc_wr_stream.sv
module tb_noc_wr_stream;
    localparam int         WORD_W      = 64;
    localparam int         BLOCK_WORDS = 25;
    localparam int         FIFO_DEPTH  = 4;
    localparam logic [7:0] DEV_ID      = 8'h01;
    localparam int         WB          = WORD_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_wr_stream_if #(.WORD_W(WORD_W)) bus ();

    noc_wr_stream #(
        .WORD_W(WORD_W), .BLOCK_WORDS(BLOCK_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH), .DEV_ID(DEV_ID)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [WORD_W-1:0] w;
        logic              first;
    } word_t;

    typedef struct {
        logic       ctl;
        logic [7:0] d;
        logic       last;
    } rbyte_t;

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] dest;
        logic [7:0] src;
        logic [7:0] exp_hdr;
        logic [7:0] exp_len;
    } vec_t;

    word_t  exp_words[$];
    rbyte_t exp_rsp[$];
    vec_t   vecs[9];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_words_seen = 0;
    int  n_first_seen = 0;
    bit  rx_active = 1'b0;
    bit  rand_stall = 1'b0;

    logic [WORD_W-1:0] m_word = '0;
    int                m_idx = 0;
    int                m_pushed = 0;
    int                m_keep = -1;
    logic [7:0]        seq = 8'h00;

    word_t  mon_w;
    rbyte_t mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench model of the byte packer and block framing.
    task automatic model_byte(input logic [7:0] b);
        m_word[8*m_idx +: 8] = b;
        m_idx++;
        if (m_idx == WB) begin
            if (m_keep != 0) begin
                exp_words.push_back('{w: m_word, first: ((m_pushed % BLOCK_WORDS) == 0)});
                m_pushed++;
                if (m_keep > 0) m_keep--;
            end
            m_idx = 0;
        end
    endtask

    task automatic send_byte(input logic c, input logic [7:0] d);
        bus.noc_to_dev_ctl  = c;
        bus.noc_to_dev_data = d;
        if (rand_stall) bus.stopin = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        bus.noc_to_dev_ctl  = 1'b0;
        bus.noc_to_dev_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) send_byte(1'b0, 8'h00);
    endtask

    task automatic push_err(input logic [7:0] code);
        exp_rsp.push_back('{ctl: 1'b1, d: 8'h05, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: 8'h00, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: DEV_ID, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: 8'h42, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: code, last: 1'b1});
    endtask

    task automatic send_write(input logic [7:0] hdr, input logic [7:0] dest,
                              input logic [7:0] src, input logic [7:0] start,
                              input logic [7:0] exp_hdr, input logic [7:0] exp_len);
        int n_addr;
        int n_data;
        logic [7:0] b;
        n_addr = 1 << hdr[7:6];
        n_data = 1 << hdr[5:3];
        $display("[TB] write hdr=%h dest=%h src=%h addr=%0d data=%0d", hdr, dest, src, n_addr, n_data);
        send_byte(1'b1, hdr);
        send_byte(1'b0, dest);
        send_byte(1'b0, src);
        for (int i = 0; i < n_addr; i++) send_byte(1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < n_data; i++) begin
            b = start + 8'(i);
            model_byte(b);
            send_byte(1'b0, b);
        end
        exp_rsp.push_back('{ctl: 1'b1, d: exp_hdr, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: src, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: dest, last: 1'b0});
        exp_rsp.push_back('{ctl: 1'b0, d: exp_len, last: 1'b1});
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        rand_stall = 1'b0;
        bus.stopin = 1'b0;
        while ((exp_words.size() != 0 || exp_rsp.size() != 0 || rx_active) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drain"}, 64'(exp_words.size() + exp_rsp.size()), 64'd0);
    endtask

    task automatic flush_model();
        exp_words.delete();
        exp_rsp.delete();
        m_word = '0;
        m_idx = 0;
        m_pushed = 0;
        m_keep = -1;
        n_words_seen = 0;
        n_first_seen = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Output monitor: sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (bus.pushin && !bus.stopin) begin
                n_words_seen++;
                if (bus.firstin) n_first_seen++;
                if (exp_words.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL word_unexpected: got %h expected none", bus.din);
                end else begin
                    mon_w = exp_words.pop_front();
                    check("word_din", 64'(bus.din), 64'(mon_w.w));
                    check("word_first", 64'(bus.firstin), 64'(mon_w.first));
                end
            end
            if (!rx_active && bus.noc_from_dev_ctl) rx_active = 1'b1;
            if (rx_active) begin
                if (exp_rsp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %0h expected none", bus.noc_from_dev_data);
                    rx_active = 1'b0;
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_ctl", 64'(bus.noc_from_dev_ctl), 64'(mon_r.ctl));
                    check("rsp_byte", 64'(bus.noc_from_dev_data), 64'(mon_r.d));
                    if (mon_r.last) rx_active = 1'b0;
                end
            end else begin
                check("rsp_idle", 64'(bus.noc_from_dev_data), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{8'h3A, 8'h11, 8'h22, 8'h04, 8'h80};
        vecs[1] = '{8'h32, 8'h11, 8'h22, 8'h04, 8'h40};
        vecs[2] = '{8'h1A, 8'h11, 8'h22, 8'h04, 8'h08};
        vecs[3] = '{8'h1A, 8'h11, 8'h22, 8'h04, 8'h08};
        vecs[4] = '{8'hD2, 8'h33, 8'h44, 8'h04, 8'h04};
        vecs[5] = '{8'h4A, 8'h33, 8'h44, 8'h04, 8'h02};
        vecs[6] = '{8'h82, 8'h33, 8'h44, 8'h04, 8'h01};
        vecs[7] = '{8'h12, 8'h33, 8'h44, 8'h04, 8'h04};
        vecs[8] = '{8'h2A, 8'h33, 8'h44, 8'h04, 8'h20};

        bus.noc_to_dev_ctl  = 1'b0;
        bus.noc_to_dev_data = 8'h00;
        bus.stopin          = 1'b0;
        rst_n               = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 64'(bus.noc_from_dev_ctl), 64'd0);
        check("rst_data", 64'(bus.noc_from_dev_data), 64'd0);
        check("rst_pushin", 64'(bus.pushin), 64'd0);
        check("rst_firstin", 64'(bus.firstin), 64'd0);
        check("rst_din", 64'(bus.din), 64'd0);
        rst_n = 1'b1;

        // Basic write with latency checks.
        send_write(8'h1A, 8'h05, 8'h09, 8'h01, 8'h04, 8'h08);
        check("basic_pushin", 64'(bus.pushin), 64'd1);
        check("basic_first", 64'(bus.firstin), 64'd1);
        check("basic_din", 64'(bus.din), 64'h0807060504030201);
        check("rsp_lat_early", 64'(bus.noc_from_dev_ctl), 64'd0);
        @(posedge clk);
        #1;
        check("rsp_lat", 64'({bus.noc_from_dev_ctl, bus.noc_from_dev_data}), 64'h104);
        drain("basic");

        // Block framing: 128+64+8+8 bytes -> 26 words.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_write(vecs[i].hdr, vecs[i].dest, vecs[i].src, seq, vecs[i].exp_hdr, vecs[i].exp_len);
            seq = seq + 8'h11;
            idle(2);
        end
        drain("frame");
        check("frame_words", 64'(n_words_seen), 64'd26);
        check("frame_first", 64'(n_first_seen), 64'd2);

        // Mixed address lengths and sub-word payloads with random stalls.
        rand_stall = 1'b1;
        for (int i = 4; i < 9; i++) begin
            send_write(vecs[i].hdr, vecs[i].dest, vecs[i].src, seq, vecs[i].exp_hdr, vecs[i].exp_len);
            seq = seq + 8'h23;
            idle(4);
        end
        drain("mixed");

        // Overflow: perm stalled during a 64-byte write.
        do_reset();
        bus.stopin = 1'b1;
        m_keep = 4;
        send_write(8'h32, 8'h05, 8'h09, 8'h40, 8'h84, 8'h40);
        t = 0;
        while ((exp_rsp.size() != 0 || rx_active) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ovf_rsp_done", 64'(exp_rsp.size()), 64'd0);
        check("ovf_pushin", 64'(bus.pushin), 64'd1);
        check("ovf_first", 64'(bus.firstin), 64'd1);
        check("ovf_din", 64'(bus.din), 64'(exp_words[0].w));
        repeat (3) @(posedge clk);
        #1;
        check("ovf_hold", 64'(bus.din), 64'(exp_words[0].w));
        m_keep = -1;
        drain("ovf");
        check("ovf_words", 64'(n_words_seen), 64'd4);

        // Zero destination ID.
        do_reset();
        $display("[TB] zero id");
        send_byte(1'b1, 8'h1A);
        send_byte(1'b0, 8'h00);
        push_err(8'h03);
        repeat (5) send_byte(1'b0, 8'hAA);
        drain("zid");
        check("zid_empty", 64'(bus.pushin), 64'd0);
        send_write(8'h1A, 8'h05, 8'h09, 8'h10, 8'h04, 8'h08);
        drain("zid_after");

        // Read command and an unknown command.
        $display("[TB] read cmd");
        send_byte(1'b1, 8'h01);
        push_err(8'h04);
        idle(3);
        drain("read");
        $display("[TB] unknown cmd");
        send_byte(1'b1, 8'h07);
        repeat (4) send_byte(1'b0, 8'h5A);
        drain("unknown");

        // Abort after 3 data bytes: no response, partial word discarded.
        $display("[TB] abort");
        send_byte(1'b1, 8'h1A);
        send_byte(1'b0, 8'h05);
        send_byte(1'b0, 8'h09);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'hE1);
        send_byte(1'b0, 8'hE2);
        send_byte(1'b0, 8'hE3);
        send_write(8'h1A, 8'h05, 8'h09, 8'h30, 8'h04, 8'h08);
        drain("abort");

        // Asynchronous reset in the middle of a response.
        bus.stopin = 1'b1;
        send_write(8'h1A, 8'h05, 8'h09, 8'h50, 8'h04, 8'h08);
        @(posedge clk);
        #1;
        check("pre_rst_ctl", 64'(bus.noc_from_dev_ctl), 64'd1);
        check("pre_rst_pushin", 64'(bus.pushin), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctl", 64'(bus.noc_from_dev_ctl), 64'd0);
        check("arst_data", 64'(bus.noc_from_dev_data), 64'd0);
        check("arst_pushin", 64'(bus.pushin), 64'd0);
        check("arst_firstin", 64'(bus.firstin), 64'd0);
        check("arst_din", 64'(bus.din), 64'd0);
        flush_model();
        bus.stopin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_write(8'h1A, 8'h05, 8'h09, 8'h70, 8'h04, 8'h08);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
